cla_seq_adder: RTL and testbench

Multi-cycle wide adder controller that reuses one 4-bit carry-lookahead slice across successive cycles. It sequences a WIDTH-bit addition as WIDTH/4 chunk operations, least significant chunk first, and chains the carry and group generate/propagate terms between chunks in registers. It sits between a requester (valid/ready in) and a consumer (valid/ready out), where area matters more than single-cycle latency.

---
 rtl/cla_seq_adder.sv | 139 +++++++++++++
 tb/tb_cla_seq_adder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder built from a single reused 4-bit carry-lookahead
// slice. Chunks are processed LSB first, and carry and group G/P are chained in registers.

module cla_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       c3,
  output logic       c4
);
  logic [3:0] pi, gi;
  logic       c1, c2;

  assign pi = a ^ b;
  assign gi = a & b;
  assign c1 = gi[0] | (pi[0] & c0);
  assign c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
  assign c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
            | (pi[2] & pi[1] & pi[0] & c0);
  assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
            | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p  = &pi;
  assign c4 = g | (p & c0);
  assign s  = pi ^ {c3, c2, c1, c0};
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_g,
  output logic             grp_p
);
  localparam int NCHUNK = WIDTH / 4;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nx;
  logic [NCHUNK-1:0][3:0] a_r, b_r, sum_r;
  logic [IDXW-1:0]        idx;
  logic                   carry_r, g_acc, p_acc, msb_cin_r;
  logic [3:0]             ca, cb, cs;
  logic                   cg, cp, cc3, cc4, last;

  // Decoded mux keeps the chunk select free of out-of-range indexing.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDXW'(k)) begin
        ca = a_r[k];
        cb = b_r[k];
      end
    end
  end

  assign last = (idx == IDXW'(NCHUNK - 1));

  cla_slice u_slice (
    .a  (ca),
    .b  (cb),
    .c0 (carry_r),
    .s  (cs),
    .g  (cg),
    .p  (cp),
    .c3 (cc3),
    .c4 (cc4)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      g_acc     <= 1'b0;
      p_acc     <= 1'b0;
      msb_cin_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          carry_r <= cin;
          g_acc   <= 1'b0;
          p_acc   <= 1'b1;
          sum_r   <= '0;
          idx     <= '0;
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++)
            if (idx == IDXW'(k)) sum_r[k] <= cs;
          carry_r <= cc4;
          g_acc   <= cg | (cp & g_acc);
          p_acc   <= p_acc & cp;
          if (last) msb_cin_r <= cc3;
          else      idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry_r;
  assign ovf       = msb_cin_r ^ carry_r;
  assign grp_g     = g_acc;
  assign grp_p     = p_acc;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: WIDTH=4/16/32 instances checked against an
// arithmetic model (a+b+cin, two's complement overflow, word G/P).

module tb_cla_seq_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        gg;
    logic        gp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0, b_in = '0;
  logic        cin = 1'b0;
  logic [2:0]  iv = '0, ordy = '0;

  logic        ir4, ir16, ir32, ov4, ov16, ov32;
  logic        co4, co16, co32, of4, of16, of32;
  logic        gg4, gg16, gg32, gp4, gp16, gp32;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;

  int pass_cnt = 0, chk_cnt = 0;
  int acc_cnt [3] = '{0, 0, 0};
  int hs_cnt  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4), .a(a_in[3:0]), .b(b_in[3:0]),
    .cin(cin), .out_valid(ov4), .out_ready(ordy[0]), .sum(s4), .cout(co4), .ovf(of4),
    .grp_g(gg4), .grp_p(gp4));
  cla_seq_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir16), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin), .out_valid(ov16), .out_ready(ordy[1]), .sum(s16), .cout(co16), .ovf(of16),
    .grp_g(gg16), .grp_p(gp16));
  cla_seq_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir32), .a(a_in), .b(b_in),
    .cin(cin), .out_valid(ov32), .out_ready(ordy[2]), .sum(s32), .cout(co32), .ovf(of32),
    .grp_g(gg32), .grp_p(gp32));

  function automatic int wid(input int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 32;
  endfunction

  function automatic logic inready(input int d);
    return (d == 0) ? ir4 : (d == 1) ? ir16 : ir32;
  endfunction

  function automatic logic outvalid(input int d);
    return (d == 0) ? ov4 : (d == 1) ? ov16 : ov32;
  endfunction

  function automatic res_t get_res(input int d);
    res_t r;
    case (d)
      0:       r = '{s: {28'd0, s4},  co: co4,  ov: of4,  gg: gg4,  gp: gp4};
      1:       r = '{s: {16'd0, s16}, co: co16, ov: of16, gg: gg16, gp: gp16};
      default: r = '{s: s32,          co: co32, ov: of32, gg: gg32, gp: gp32};
    endcase
    return r;
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result sign bits.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
    longint unsigned m, aa, bb, t, t0;
    res_t r;
    m  = (64'd1 << w) - 64'd1;
    aa = 64'(a) & m;
    bb = 64'(b) & m;
    t  = aa + bb + 64'(c);
    t0 = aa + bb;
    r.s  = 32'(t & m);
    r.co = t[w];
    r.gg = t0[w];
    r.gp = ((aa ^ bb) == m);
    r.ov = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (iv[d] && inready(d))    acc_cnt[d] = acc_cnt[d] + 1;
        if (outvalid(d) && ordy[d]) hs_cnt[d]  = hs_cnt[d] + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit seen;
    res_t r;
    rst = 1'b1; iv = '0; ordy = '0;
    tick; tick;
    rst = 1'b0;
    chk_cnt++;
    if (inready(1) !== 1'b1 || outvalid(1) !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", inready(1), outvalid(1));
    else pass_cnt++;
    r = get_res(1);
    chk_cnt++;
    if (r !== res_t'(0)) $display("FAIL reset_outs: got %h want 0", r);
    else pass_cnt++;
    // Start an op, then reset once idx reaches 2.
    a_in = 32'hFFFF; b_in = 32'h0001; cin = 1'b0; iv[1] = 1'b1;
    tick;
    iv[1] = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    chk_cnt++;
    if (outvalid(1) !== 1'b0 || inready(1) !== 1'b1)
      $display("FAIL reset_mid_run1: out_valid=%b in_ready=%b want 0/1", outvalid(1), inready(1));
    else pass_cnt++;
    tick;
    rst = 1'b0;
    r = get_res(1);
    chk_cnt++;
    if (inready(1) !== 1'b1 || r !== res_t'(0))
      $display("FAIL reset_mid_run2: in_ready=%b outs=%h want 1/0", inready(1), r);
    else pass_cnt++;
    ordy[1] = 1'b1;
    seen = 0;
    repeat (6) begin
      tick;
      if (outvalid(1)) seen = 1;
    end
    ordy[1] = 1'b0;
    chk_cnt++;
    if (seen) $display("FAIL reset_abort: out_valid rose after aborted op, want never");
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [31:0] ta [3] = '{32'hFFFF, 32'h7FFF, 32'hAAAA};
    logic [31:0] tb [3] = '{32'h0001, 32'h0001, 32'h5555};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    res_t        te [3] = '{'{s: 32'h0000, co: 1'b1, ov: 1'b0, gg: 1'b1, gp: 1'b0},
                            '{s: 32'h8000, co: 1'b0, ov: 1'b1, gg: 1'b0, gp: 1'b0},
                            '{s: 32'h0000, co: 1'b1, ov: 1'b0, gg: 1'b0, gp: 1'b1}};
    int n;
    res_t r;
    for (int i = 0; i < 3; i++) begin
      a_in = ta[i]; b_in = tb[i]; cin = tc[i];
      iv[1] = 1'b1; ordy[1] = 1'b1;
      chk_cnt++;
      if (inready(1) !== 1'b1) $display("FAIL dir%0d_ready: in_ready=%b want 1", i, inready(1));
      else pass_cnt++;
      tick;
      iv[1] = 1'b0; a_in = $urandom; b_in = $urandom; cin = ~cin;
      n = 0;
      while (!outvalid(1) && n < 40) begin tick; n++; end
      chk_cnt++;
      if (n !== 4) $display("FAIL dir%0d_latency: got %0d want 4", i, n);
      else pass_cnt++;
      r = get_res(1);
      chk_cnt++;
      if (r !== te[i]) $display("FAIL dir%0d_result: got %h want %h", i, r, te[i]);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (outvalid(1) !== 1'b0 || inready(1) !== 1'b1)
        $display("FAIL dir%0d_release: out_valid=%b in_ready=%b want 0/1", i, outvalid(1), inready(1));
      else pass_cnt++;
      ordy[1] = 1'b0;
    end
  endtask

  task automatic test_latency;
    int n;
    res_t e, r;
    for (int d = 0; d < 3; d++) begin
      a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1));
      e = model(wid(d), a_in, b_in, cin);
      iv[d] = 1'b1; ordy[d] = 1'b1;
      tick;
      iv[d] = 1'b0;
      n = 0;
      while (!outvalid(d) && n < 40) begin tick; n++; end
      chk_cnt++;
      if (n !== wid(d) / 4) $display("FAIL lat_w%0d: got %0d want %0d", wid(d), n, wid(d) / 4);
      else pass_cnt++;
      r = get_res(d);
      chk_cnt++;
      if (r !== e) $display("FAIL lat_w%0d_result: got %h want %h", wid(d), r, e);
      else pass_cnt++;
      tick;
      ordy[d] = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    res_t ea, eb, r;
    logic [31:0] na, nb;
    logic nc;
    int n;
    a_in = $urandom; b_in = $urandom; cin = 1'b1;
    ea = model(16, a_in, b_in, cin);
    iv[1] = 1'b1; ordy[1] = 1'b0;
    tick;
    iv[1] = 1'b0;
    n = 0;
    while (!outvalid(1) && n < 40) begin tick; n++; end
    na = $urandom; nb = $urandom; nc = 1'b0;
    eb = model(16, na, nb, nc);
    a_in = na; b_in = nb; cin = nc; iv[1] = 1'b1;
    repeat (5) begin
      r = get_res(1);
      chk_cnt++;
      if (outvalid(1) !== 1'b1 || inready(1) !== 1'b0 || r !== ea)
        $display("FAIL bp_hold: ov=%b ir=%b res=%h want 1/0/%h", outvalid(1), inready(1), r, ea);
      else pass_cnt++;
      tick;
    end
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
    chk_cnt++;
    if (outvalid(1) !== 1'b0 || inready(1) !== 1'b1)
      $display("FAIL bp_release: ov=%b ir=%b want 0/1", outvalid(1), inready(1));
    else pass_cnt++;
    tick;
    iv[1] = 1'b0;
    chk_cnt++;
    if (inready(1) !== 1'b0) $display("FAIL bp_accept: in_ready=%b want 0", inready(1));
    else pass_cnt++;
    n = 0;
    while (!outvalid(1) && n < 40) begin tick; n++; end
    r = get_res(1);
    chk_cnt++;
    if (n !== 4 || r !== eb) $display("FAIL bp_second: lat=%0d res=%h want 4/%h", n, r, eb);
    else pass_cnt++;
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
  endtask

  task automatic test_random(input int d, input int nvec);
    int a0, h0, t;
    bit got;
    res_t e, r;
    a0 = acc_cnt[d]; h0 = hs_cnt[d];
    iv = '0; ordy = '0;
    tick;
    for (int i = 0; i < nvec; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1));
      e = model(wid(d), a_in, b_in, cin);
      iv[d] = 1'b1;
      t = 0;
      while (!inready(d) && t < 50) begin tick; t++; end
      tick;
      iv[d] = 1'b0; a_in = $urandom; b_in = $urandom; cin = 1'($urandom_range(0, 1));
      got = 0; t = 0;
      while (!got && t < 200) begin
        if (outvalid(d)) begin
          r = get_res(d);
          chk_cnt++;
          if (r !== e) $display("FAIL rand_w%0d_v%0d: got %h want %h", wid(d), i, r, e);
          else pass_cnt++;
          ordy[d] = 1'($urandom_range(0, 1));
          if (ordy[d]) got = 1;
        end else begin
          ordy[d] = 1'($urandom_range(0, 1));
        end
        tick;
        t++;
      end
      ordy[d] = 1'b0;
      chk_cnt++;
      if (!got) $display("FAIL rand_w%0d_v%0d_timeout: no result within %0d cycles", wid(d), i, t);
      else if (outvalid(d) !== 1'b0)
        $display("FAIL rand_w%0d_v%0d_dup: out_valid=%b after handshake want 0", wid(d), i, outvalid(d));
      else pass_cnt++;
    end
    chk_cnt++;
    if (acc_cnt[d] - a0 !== nvec || hs_cnt[d] - h0 !== nvec)
      $display("FAIL rand_w%0d_count: accepts=%0d results=%0d want %0d", wid(d),
               acc_cnt[d] - a0, hs_cnt[d] - h0, nvec);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_latency;
    test_backpressure;
    test_random(0, 1000);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
